// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared constants and payload layout for the MIPS pipeline registers
package mips_pipe_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int WB_W_DEF       = 2;
    localparam int MEM_W_DEF      = 3;

    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;
    localparam int MEM_BRANCH   = 2;
    localparam int MEM_MEMREAD  = 1;
    localparam int MEM_MEMWRITE = 0;

    // Field order matches the flat vector packed by exe_mem_stage_reg.
    typedef struct packed {
        logic [DATA_W_DEF-1:0]     add_pc;
        logic [DATA_W_DEF-1:0]     alu_result;
        logic                      zero;
        logic [DATA_W_DEF-1:0]     read_data2;
        logic [REG_ADDR_W_DEF-1:0] dest_reg;
        logic [WB_W_DEF-1:0]       wb;
        logic [MEM_W_DEF-1:0]      mem;
    } exe_mem_payload_t;

    localparam int PAYLOAD_W_DEF = $bits(exe_mem_payload_t);

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - payload holding register with load and clear
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exe_mem_stage_reg.sv
// rtl/exe_mem_stage_reg.sv - elastic EX/MEM pipeline register with skid slot, flush and forwarding tap
module exe_mem_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int WB_W       = WB_W_DEF,
    parameter int MEM_W      = MEM_W_DEF,
    parameter int SKID       = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     addPc,
    input  logic [DATA_W-1:0]     aluResult,
    input  logic                  zero,
    input  logic [DATA_W-1:0]     readData2,
    input  logic [REG_ADDR_W-1:0] muxInst,
    input  logic [WB_W-1:0]       WB,
    input  logic [MEM_W-1:0]      MEM,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     addPcOut,
    output logic [DATA_W-1:0]     aluResultOut,
    output logic                  zeroOut,
    output logic [DATA_W-1:0]     readData2Out,
    output logic [REG_ADDR_W-1:0] muxInstOut,
    output logic [WB_W-1:0]       WBOut,
    output logic [MEM_W-1:0]      MEMOut,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data
);

    localparam int PW       = 3 * DATA_W + 1 + REG_ADDR_W + WB_W + MEM_W;
    localparam bit HAS_SKID = (SKID != 0);

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] out_d;

    logic ov, sv, ready_q;
    logic ov_next, sv_next;
    logic in_xfer, out_xfer;
    logic out_load, out_clear, out_from_skid;
    logic skid_load, skid_clear;

    assign in_payload = {addPc, aluResult, zero, readData2, muxInst, WB, MEM};
    assign {addPcOut, aluResultOut, zeroOut, readData2Out, muxInstOut, WBOut, MEMOut} = out_q;
    assign out_valid  = ov;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = ov && out_ready;

    // Emptying the output slot always clears it, so a bubble never carries WB/MEM enables.
    always_comb begin
        ov_next       = ov;
        sv_next       = sv;
        out_load      = 1'b0;
        out_clear     = 1'b0;
        out_from_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            ov_next    = 1'b0;
            sv_next    = 1'b0;
            out_clear  = 1'b1;
            skid_clear = 1'b1;
        end else if (sv) begin
            if (out_xfer) begin
                out_load      = 1'b1;
                out_from_skid = 1'b1;
                sv_next       = 1'b0;
                skid_clear    = 1'b1;
            end
        end else if (ov) begin
            if (in_xfer && out_xfer) begin
                out_load = 1'b1;
            end else if (in_xfer) begin
                skid_load = 1'b1;
                sv_next   = 1'b1;
            end else if (out_xfer) begin
                ov_next   = 1'b0;
                out_clear = 1'b1;
            end
        end else if (in_xfer) begin
            out_load = 1'b1;
            ov_next  = 1'b1;
        end
        out_d = out_from_skid ? skid_q : in_payload;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ov      <= 1'b0;
            sv      <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            ov      <= ov_next;
            sv      <= sv_next && HAS_SKID;
            ready_q <= !(ov_next && sv_next);
        end
    end

    pipe_skid_slot #(.W(PW)) u_out_slot (
        .clock (clock),
        .reset (reset),
        .clear (out_clear),
        .load  (out_load),
        .d     (out_d),
        .q     (out_q)
    );

    generate
        if (HAS_SKID) begin : g_skid
            assign in_ready = ready_q;
            pipe_skid_slot #(.W(PW)) u_skid_slot (
                .clock (clock),
                .reset (reset),
                .clear (skid_clear),
                .load  (skid_load),
                .d     (in_payload),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign in_ready = out_ready || !ov;
            assign skid_q   = '0;
        end
    endgenerate

    assign fwd_valid = ov && WBOut[WB_REGWRITE] && (muxInstOut != '0);
    assign fwd_reg   = muxInstOut;
    assign fwd_data  = aluResultOut;

endmodule
